alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU instance among NUM_REQ requesters (e.g. issue slot, address-gen, debug port).
//  Round-robin grant, valid/ready request and response handshakes, registered operands and result.
//  Sits between requesters and the ALU. Drives alu_op1/alu_op2/alu_sel and samples alu_out.
// PARAMETERS
//  NUM_REQ   2   number of requesters, 1..8
//  DATA_W    32  operand/result width; must equal ALU width
//  SEL_W     4   ALU select width; encodings are the `ALUSel_* macros
//  ID_W      derived: max(1,$clog2(NUM_REQ)); not user-overridable
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  reset, asynchronous, active-low
//  req_valid  in   NUM_REQ            per-requester request valid
//  req_ready  out  NUM_REQ            per-requester accept; at most one bit high
//  req_op1    in   NUM_REQ*DATA_W     operand 1, requester i at [i*DATA_W +: DATA_W]
//  req_op2    in   NUM_REQ*DATA_W     operand 2, same packing
//  req_sel    in   NUM_REQ*SEL_W      ALU select, same packing
//  rsp_valid  out  1                  result valid
//  rsp_ready  in   1                  result consumer ready
//  rsp_id     out  ID_W               index of requester owning rsp_data
//  rsp_data   out  DATA_W             ALU result
//  alu_op1    out  DATA_W             to ALU op1
//  alu_op2    out  DATA_W             to ALU op2
//  alu_sel    out  SEL_W              to ALU aluSel
//  alu_out    in   DATA_W             from ALU aluOut (combinational)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, rr_ptr=0.
//   - Operand, select, result and id registers clear to 0.
//   - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_op1/alu_op2/alu_sel=0.
//   - An in-flight op is dropped. No response is issued for it.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//   - If any req_valid, grant g = first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - req_ready[g]=1 combinationally in that cycle; the handshake is req_valid[g]&req_ready[g].
//   - On the handshake: latch op1/op2/sel into the alu_* registers, id_q=g, rr_ptr=(g+1)%NUM_REQ, go EXEC.
//   - With no valid request: stay in IDLE; all regs hold.
//  EXEC:
//   - alu_* are stable (registered).
//   - result_q<=alu_out at the clock edge; go RESP.
//   - req_ready=0.
//  RESP:
//   - rsp_valid=1, rsp_data=result_q, rsp_id=id_q.
//   - rsp_valid/rsp_data/rsp_id hold stable until rsp_ready. On rsp_valid&rsp_ready go IDLE. req_ready=0.
//  Latency and throughput:
//   - Accept at cycle N -> rsp_valid at N+2 (earliest).
//   - Max throughput is 1 op per 3 cycles. A new accept is not allowed in the RESP cycle.
//  alu_* keep their last values outside EXEC; no glitching to 0.
//  Requesters hold req_* stable while req_valid and not yet accepted. Non-granted requesters simply wait.
//  Fairness: a continuously valid requester is granted within NUM_REQ grants.
//  NUM_REQ=1: rr_ptr is constant 0; rsp_id is constant 0.
//  Undefined sel (no `ALUSel_* match): forwarded unchanged. rsp_data is whatever the ALU returns; no error flag.
//  Simultaneous req_valid deasserting in the same IDLE cycle it is granted is a protocol violation. The handshake still completes.
// CONFIGURATION
//  ALU_ARB_OPCNT_EN defined:
//   - Adds output op_cnt [15:0]: count of completed responses (rsp_valid&rsp_ready).
//   - Saturates at 16'hFFFF. Reset value 0.
//  ALU_ARB_OPCNT_EN undefined:
//   - op_cnt port and counter are absent.
//   - Behaviour is otherwise identical.
// TESTING
//  1. Reset: hold rst=0 mid-EXEC -> next cycle state IDLE, rsp_valid=0, alu_op1=0, no response emitted after release.
//  2. Single op: req0 op1=5 op2=3 sel=`ALUSel_ADD at N -> req_ready[0]=1 @N, rsp_valid @N+2, rsp_data=8, rsp_id=0.
//  3. Backpressure: `ALUSel_SUB 3-5 with rsp_ready=0 for 4 cycles -> rsp_valid held with rsp_data=32'hFFFFFFFE stable; completes on rsp_ready.
//  4. Round-robin: req0 and req1 both valid continuously, NUM_REQ=2 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
//  5. Shift/SLT pass-through: `ALUSel_SRA op1=32'h80000000 op2=4 -> 32'hF8000000; `ALUSel_SLT op1=-1 op2=1 -> 1.
//  6. With ALU_ARB_OPCNT_EN: 3 completed ops -> op_cnt=3; a request accepted but reset before RESP is not counted.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_arbiter                                                       |
// | Brief   : Round-robin sharing of one combinational ALU among NUM_REQ        |
// |           requesters. Uses valid/ready request/response handshakes and      |
// |           registered operands and result. Optional macro ALU_ARB_OPCNT_EN   |
// |           adds a saturating op_cnt output.                                  |
// | Rev     : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

`ifndef ALUSel_ADD
`define ALUSel_ADD  4'd0
`define ALUSel_SLL  4'd1
`define ALUSel_SLT  4'd2
`define ALUSel_SLTU 4'd3
`define ALUSel_XOR  4'd4
`define ALUSel_SRL  4'd5
`define ALUSel_OR   4'd6
`define ALUSel_AND  4'd7
`define ALUSel_SUB  4'd12
`define ALUSel_SRA  4'd13
`endif

module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_op1,
    input  logic [NUM_REQ*DATA_W-1:0]  req_op2,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [DATA_W-1:0]          alu_op1,
    output logic [DATA_W-1:0]          alu_op2,
    output logic [SEL_W-1:0]           alu_sel,
`ifdef ALU_ARB_OPCNT_EN
    output logic [15:0]                op_cnt,
`endif
    input  logic [DATA_W-1:0]          alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_result;
    logic                r_rsp_valid;
`ifdef ALU_ARB_OPCNT_EN
    logic [15:0]         r_op_cnt;
`endif

    logic                w_gnt_valid;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [ID_W-1:0]     w_next_ptr;
    logic [ID_W-1:0]     w_idx;
    logic [DATA_W-1:0]   w_op1;
    logic [DATA_W-1:0]   w_op2;
    logic [SEL_W-1:0]    w_sel;
    logic [NUM_REQ-1:0]  w_ready;

    // Scan from the farthest offset down so the one closest to rr_ptr wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_next_ptr  = '0;
        w_idx       = '0;
        w_op1       = '0;
        w_op2       = '0;
        w_sel       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_idx;
                w_next_ptr  = ID_W'((int'(w_idx) + 1) % NUM_REQ);
                w_op1       = req_op1[w_idx*DATA_W +: DATA_W];
                w_op2       = req_op2[w_idx*DATA_W +: DATA_W];
                w_sel       = req_sel[w_idx*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_gnt_valid) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_sel       <= '0;
            r_result    <= '0;
            r_rsp_valid <= 1'b0;
`ifdef ALU_ARB_OPCNT_EN
            r_op_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_op1    <= w_op1;
                        r_op2    <= w_op2;
                        r_sel    <= w_sel;
                        r_id     <= w_gnt_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result    <= alu_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
`ifdef ALU_ARB_OPCNT_EN
                        if (r_op_cnt != 16'hFFFF) begin
                            r_op_cnt <= r_op_cnt + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_result;
    assign alu_op1   = r_op1;
    assign alu_op2   = r_op2;
    assign alu_sel   = r_sel;
`ifdef ALU_ARB_OPCNT_EN
    assign op_cnt    = r_op_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_arbiter                                                    |
// | Brief   : Directed self-checking bench for alu_arbiter with an ALU model.   |
// | Rev     : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

`ifndef ALUSel_ADD
`define ALUSel_ADD  4'd0
`define ALUSel_SLL  4'd1
`define ALUSel_SLT  4'd2
`define ALUSel_SLTU 4'd3
`define ALUSel_XOR  4'd4
`define ALUSel_SRL  4'd5
`define ALUSel_OR   4'd6
`define ALUSel_AND  4'd7
`define ALUSel_SUB  4'd12
`define ALUSel_SRA  4'd13
`endif

module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*DATA_W-1:0] req_op2;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [0:0]                rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic [DATA_W-1:0]         alu_op1;
    logic [DATA_W-1:0]         alu_op2;
    logic [SEL_W-1:0]          alu_sel;
    logic [DATA_W-1:0]         alu_out;
`ifdef ALU_ARB_OPCNT_EN
    logic [15:0]               op_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_sel   (alu_sel),
`ifdef ALU_ARB_OPCNT_EN
        .op_cnt    (op_cnt),
`endif
        .alu_out   (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            `ALUSel_ADD:  alu_out = alu_op1 + alu_op2;
            `ALUSel_SUB:  alu_out = alu_op1 - alu_op2;
            `ALUSel_SLL:  alu_out = alu_op1 << alu_op2[4:0];
            `ALUSel_SRL:  alu_out = alu_op1 >> alu_op2[4:0];
            `ALUSel_SRA:  alu_out = $signed(alu_op1) >>> alu_op2[4:0];
            `ALUSel_SLT:  alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            `ALUSel_SLTU: alu_out = {31'd0, alu_op1 < alu_op2};
            `ALUSel_XOR:  alu_out = alu_op1 ^ alu_op2;
            `ALUSel_OR:   alu_out = alu_op1 | alu_op2;
            `ALUSel_AND:  alu_out = alu_op1 & alu_op2;
            default:      alu_out = '0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] s);
        req_op1[idx*DATA_W +: DATA_W] = a;
        req_op2[idx*DATA_W +: DATA_W] = b;
        req_sel[idx*SEL_W +: SEL_W]   = s;
        req_valid[idx]                = 1'b1;
    endtask

    // Called just after a falling edge with rsp_ready=1.
    task automatic run_op(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] s,
                          input logic [31:0] exp, input logic [31:0] exp_id);
        int n;
        set_req(idx, a, b, s);
        #1;
        n = 0;
        while (!req_ready[idx] && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_grant"}, {31'd0, req_ready[idx]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_lat"}, n, 32'd1);
        check_eq({tag, "_data"}, rsp_data, exp);
        check_eq({tag, "_id"}, {31'd0, rsp_id}, exp_id);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic seen;
        rst       = 1'b0;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {30'd0, req_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check_eq("rst_alu_op1", alu_op1, 32'd0);
        check_eq("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single op: ADD 5+3 on requester 0
        run_op("add", 0, 32'd5, 32'd3, `ALUSel_ADD, 32'd8, 32'd0);
        check_eq("add_idle", {31'd0, rsp_valid}, 32'd0);
        check_eq("alu_hold", alu_op1, 32'd5);

        // Backpressure: SUB 3-5 on requester 1, consumer stalled 4 cycles
        rsp_ready = 1'b0;
        set_req(1, 32'd3, 32'd5, `ALUSel_SUB);
        #1;
        check_eq("bp_grant", {30'd0, req_ready}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_data", rsp_data, 32'hFFFF_FFFE);
            check_eq("bp_id", {31'd0, rsp_id}, 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_done", {31'd0, rsp_valid}, 32'd0);

        // Round-robin with both requesters continuously valid
        set_req(0, 32'd10, 32'd1, `ALUSel_ADD);
        set_req(1, 32'd20, 32'd2, `ALUSel_ADD);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rsp_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check_eq("rr_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("rr_id", {31'd0, rsp_id}, k % 2);
            check_eq("rr_data", rsp_data, (k % 2 == 0) ? 32'd11 : 32'd22);
            if (k == 3) req_valid = '0;
            @(negedge clk);
        end

        // Shift / compare pass-through
        run_op("sra", 0, 32'h8000_0000, 32'd4, `ALUSel_SRA, 32'hF800_0000, 32'd0);
        run_op("slt", 1, 32'hFFFF_FFFF, 32'd1, `ALUSel_SLT, 32'd1, 32'd1);
`ifdef ALU_ARB_OPCNT_EN
        check_eq("opcnt_8", {16'd0, op_cnt}, 32'd8);
`endif

        // Reset while an op is in EXEC
        set_req(0, 32'd7, 32'd7, `ALUSel_ADD);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("mid_rst_alu_op1", alu_op1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("mid_rst_no_rsp", {31'd0, seen}, 32'd0);
`ifdef ALU_ARB_OPCNT_EN
        check_eq("opcnt_rst", {16'd0, op_cnt}, 32'd0);
`endif
        run_op("post_rst", 1, 32'hF0, 32'h3C, `ALUSel_AND, 32'h30, 32'd1);
        run_op("xor", 0, 32'hFF00, 32'h0FF0, `ALUSel_XOR, 32'hF0F0, 32'd0);
        run_op("sll", 1, 32'd1, 32'd31, `ALUSel_SLL, 32'h8000_0000, 32'd1);
`ifdef ALU_ARB_OPCNT_EN
        check_eq("opcnt_3", {16'd0, op_cnt}, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
